// File: rtl/pe_mac_v2_if.sv
// Systolic PE port bundle: beat inputs from the array side, registered results back.
interface pe_mac_v2_if #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 32
);
  logic               pe_en;
  logic [1:0]         mode;
  logic               valid_in;
  logic               acc_clr;
  logic [OUT_LEN-1:0] westin1;
  logic [IN_LEN-1:0]  westin2;
  logic [OUT_LEN-1:0] northin;
  logic [OUT_LEN-1:0] eastout;
  logic [OUT_LEN-1:0] southout;
  logic               valid_out;
  logic               ovf;

  modport master (
    output pe_en, mode, valid_in, acc_clr, westin1, westin2, northin,
    input  eastout, southout, valid_out, ovf
  );

  modport slave (
    input  pe_en, mode, valid_in, acc_clr, westin1, westin2, northin,
    output eastout, southout, valid_out, ovf
  );
endinterface

// File: rtl/pe_mac_v2.sv
// Two-stage signed MAC processing element: stage 1 multiplies, stage 2 adds per beat mode
// with saturating or wrapping arithmetic and a sticky overflow flag.
module pe_mac_v2 #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 32,
  parameter bit SAT     = 1'b1
) (
  input  logic       clk,
  input  logic       sys_rst,
  pe_mac_v2_if.slave pe
);

  typedef enum logic [1:0] {
    MAC_H  = 2'd0,
    MAC_V  = 2'd1,
    OS_ACC = 2'd2,
    DRAIN  = 2'd3
  } mode_e;

  localparam int PW = 2 * IN_LEN;
  localparam logic [OUT_LEN-1:0] MAXV = {1'b0, {(OUT_LEN-1){1'b1}}};
  localparam logic [OUT_LEN-1:0] MINV = {1'b1, {(OUT_LEN-1){1'b0}}};

  logic                      r_v1;
  mode_e                     r_mode1;
  logic [OUT_LEN-1:0]        r_w1;
  logic [OUT_LEN-1:0]        r_n1;
  logic signed [PW-1:0]      r_p;
  logic [OUT_LEN-1:0]        r_east;
  logic [OUT_LEN-1:0]        r_south;
  logic [OUT_LEN-1:0]        r_acc;
  logic                      r_vout;
  logic                      r_ovf;

  logic signed [IN_LEN-1:0]  w_x;
  logic signed [PW-1:0]      w_prod;
  logic signed [OUT_LEN-1:0] w_pext;
  logic [OUT_LEN-1:0]        w_acc_base;
  logic [OUT_LEN:0]          w_sum;
  logic [OUT_LEN-1:0]        w_east_n;
  logic [OUT_LEN-1:0]        w_south_n;
  logic [OUT_LEN-1:0]        w_acc_n;
  logic                      w_ovf_n;

  // Returns {overflow, result}; the add runs one bit wider so the carry-out exposes overflow.
  function automatic logic [OUT_LEN:0] add_sat(input logic [OUT_LEN-1:0] a,
                                               input logic [OUT_LEN-1:0] b);
    logic [OUT_LEN:0] s;
    logic             o;
    s = {a[OUT_LEN-1], a} + {b[OUT_LEN-1], b};
    o = s[OUT_LEN] ^ s[OUT_LEN-1];
    if (o && SAT) return {1'b1, (s[OUT_LEN] ? MINV : MAXV)};
    return {o, s[OUT_LEN-1:0]};
  endfunction

  assign w_x    = (mode_e'(pe.mode) == MAC_V) ? pe.westin1[IN_LEN-1:0] : pe.northin[IN_LEN-1:0];
  assign w_prod = $signed(pe.westin2) * w_x;
  assign w_pext = OUT_LEN'(r_p);

  // acc_clr zeroes the accumulator base before a coincident OS_ACC add; DRAIN still reads the old acc.
  always_comb begin
    w_acc_base = pe.acc_clr ? '0 : r_acc;
    w_east_n   = r_east;
    w_south_n  = r_south;
    w_acc_n    = w_acc_base;
    w_ovf_n    = r_ovf & ~pe.acc_clr;
    w_sum      = '0;
    if (r_v1) begin
      unique case (r_mode1)
        MAC_H: begin
          w_sum     = add_sat(w_pext, r_w1);
          w_east_n  = w_sum[OUT_LEN-1:0];
          w_south_n = r_n1;
        end
        MAC_V: begin
          w_sum     = add_sat(w_pext, r_n1);
          w_south_n = w_sum[OUT_LEN-1:0];
          w_east_n  = r_w1;
        end
        OS_ACC: begin
          w_sum     = add_sat(w_acc_base, w_pext);
          w_acc_n   = w_sum[OUT_LEN-1:0];
          w_east_n  = r_w1;
          w_south_n = r_n1;
        end
        DRAIN: begin
          w_sum     = add_sat(r_acc, r_n1);
          w_south_n = w_sum[OUT_LEN-1:0];
          w_acc_n   = '0;
          w_east_n  = r_w1;
        end
        default: ;
      endcase
      w_ovf_n = w_ovf_n | w_sum[OUT_LEN];
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_v1    <= 1'b0;
      r_mode1 <= MAC_H;
      r_w1    <= '0;
      r_n1    <= '0;
      r_p     <= '0;
      r_east  <= '0;
      r_south <= '0;
      r_acc   <= '0;
      r_vout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (pe.pe_en) begin
      r_v1    <= pe.valid_in;
      r_mode1 <= mode_e'(pe.mode);
      r_w1    <= pe.westin1;
      r_n1    <= pe.northin;
      r_p     <= w_prod;
      r_east  <= w_east_n;
      r_south <= w_south_n;
      r_acc   <= w_acc_n;
      r_vout  <= r_v1;
      r_ovf   <= w_ovf_n;
    end
  end

  assign pe.eastout   = r_east;
  assign pe.southout  = r_south;
  assign pe.valid_out = r_vout;
  assign pe.ovf       = r_ovf;

endmodule
